ram4002_bus_seq: RTL and testbench

RAM4002_BUS_SEQ -- requirements
Module: ram4002_bus_seq

---
 rtl/ram4002_bus_seq_pkg.sv | 14 +
 rtl/ram4002_bus_seq_if.sv | 13 +
 rtl/mcs4_phase_gen.sv | 28 ++
 rtl/ram4002_bus_seq.sv | 97 +++++++++
 tb/tb_ram4002_bus_seq.sv | 129 ++++++++++++
 5 files changed

// File: rtl/ram4002_bus_seq_pkg.sv
// ram4002_bus_seq_pkg: MCS-4 RAM I/O opcodes, bus phase encoding and opcode class helpers
package ram4002_bus_seq_pkg;
   typedef enum logic [2:0] {PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3} phase_t;
   localparam logic [3:0] RAM_WRM = 4'h0, RAM_WMP = 4'h1, RAM_WRR = 4'h2, RAM_WPM = 4'h3;
   localparam logic [3:0] RAM_WR0 = 4'h4, RAM_WR1 = 4'h5, RAM_WR2 = 4'h6, RAM_WR3 = 4'h7;
   localparam logic [3:0] RAM_SBM = 4'h8, RAM_RDM = 4'h9, RAM_RDR = 4'hA, RAM_ADM = 4'hB;
   localparam logic [3:0] RAM_RD0 = 4'hC, RAM_RD1 = 4'hD, RAM_RD2 = 4'hE, RAM_RD3 = 4'hF;
   function automatic logic is_rd(input logic [3:0] op);
      return op == RAM_SBM || op == RAM_RDM || op == RAM_ADM || op >= RAM_RD0;
   endfunction
   function automatic logic is_wr(input logic [3:0] op);
      return op == RAM_WRM || op == RAM_WMP || (op >= RAM_WR0 && op <= RAM_WR3);
   endfunction
endpackage

// File: rtl/ram4002_bus_seq_if.sv
// ram4002_bus_seq_if: MCS-4 bus side and RAM side signals of the 4002 bus sequencer
interface ram4002_bus_seq_if;
   logic       sync, cm;
   logic [3:0] d_in, ram_dout;
   logic [5:0] ram_addr;
   logic [3:0] ram_opa, ram_din, d_out;
   logic       ram_cs, ram_we, ram_reset_n, d_oe, sync_err;
   logic [2:0] phase;
   modport slave(input sync, cm, d_in, ram_dout,
                 output ram_addr, ram_opa, ram_cs, ram_we, ram_din, ram_reset_n, d_out, d_oe, phase, sync_err);
   modport master(output sync, cm, d_in, ram_dout,
                  input ram_addr, ram_opa, ram_cs, ram_we, ram_din, ram_reset_n, d_out, d_oe, phase, sync_err);
endinterface

// File: rtl/mcs4_phase_gen.sv
// mcs4_phase_gen: eight-phase MCS-4 bus counter with lock-on-first-sync and sticky sync-loss check
module mcs4_phase_gen import ram4002_bus_seq_pkg::*; (
   input  logic   clk,
   input  logic   reset,
   input  logic   i_en,
   input  logic   i_sync,
   output phase_t o_phase,
   output logic   o_locked,
   output logic   o_sync_err
);
   phase_t r_phase;
   logic   r_locked, r_sync_err;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase    <= PH_A1;
         r_locked   <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_phase    <= i_sync ? PH_A1 : phase_t'(r_phase + 3'd1);
         r_locked   <= r_locked | (i_en & i_sync);
         // sync belongs in X3 and only there
         r_sync_err <= r_sync_err | (r_locked & ((r_phase == PH_X3) ? !i_sync : i_sync));
      end
   end
   assign o_phase    = r_phase;
   assign o_locked   = r_locked;
   assign o_sync_err = r_sync_err;
endmodule

// File: rtl/ram4002_bus_seq.sv
// ram4002_bus_seq: decodes SRC and RAM I/O instructions off the MCS-4 bus into single-clock RAM strobes
module ram4002_bus_seq import ram4002_bus_seq_pkg::*; #(
   parameter logic [1:0] CHIP_ID     = 2'd0,
   parameter int         INIT_CYCLES = 64
) (
   input logic              clk,
   input logic              reset,
   ram4002_bus_seq_if.slave bus
);
   localparam int CW = $clog2(INIT_CYCLES + 1);
   phase_t        w_phase;
   logic          w_locked, w_sync_err, w_abort;
   logic [CW-1:0] r_init_cnt;
   logic          r_init_done, r_sel, r_io_pend, r_src_pend, r_src_sel, r_cs, r_we, r_oe;
   logic [1:0]    r_src_reg;
   logic [5:0]    r_addr;
   logic [3:0]    r_opa, r_din, r_dout;
   mcs4_phase_gen u_phase (
      .clk        (clk),
      .reset      (reset),
      .i_en       (r_init_done),
      .i_sync     (bus.sync),
      .o_phase    (w_phase),
      .o_locked   (w_locked),
      .o_sync_err (w_sync_err)
   );
   assign w_abort = bus.sync && w_phase != PH_X3;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_init_cnt  <= '0;
         r_init_done <= 1'b0;
         r_sel       <= 1'b0;
         r_io_pend   <= 1'b0;
         r_src_pend  <= 1'b0;
         r_src_sel   <= 1'b0;
         r_src_reg   <= 2'd0;
         r_addr      <= 6'd0;
         r_opa       <= 4'd0;
         r_din       <= 4'd0;
         r_dout      <= 4'd0;
         r_cs        <= 1'b0;
         r_we        <= 1'b0;
         r_oe        <= 1'b0;
      end else begin
         if (!r_init_done) r_init_cnt <= r_init_cnt + 1'b1;
         r_init_done <= r_init_done | (r_init_cnt == CW'(INIT_CYCLES - 1));
         r_cs <= 1'b0;
         r_we <= 1'b0;
         r_oe <= 1'b0;
         if (w_abort) begin
            r_io_pend  <= 1'b0;
            r_src_pend <= 1'b0;
         end else if (w_locked) begin
            if (w_phase == PH_M2) begin
               r_io_pend <= bus.cm && r_sel;
               if (bus.cm && r_sel) begin
                  r_opa <= bus.d_in;
                  r_cs  <= is_rd(bus.d_in);
               end
            end
            if (w_phase == PH_X1 && r_cs) begin
               r_dout <= bus.ram_dout;
               r_oe   <= 1'b1;
            end
            if (w_phase == PH_X2) begin
               if (r_io_pend && is_wr(r_opa)) begin
                  r_din <= bus.d_in;
                  r_cs  <= 1'b1;
                  r_we  <= 1'b1;
               end
               // SRC is staged so an access in this same cycle still sees the old address
               if (bus.cm) begin
                  r_src_pend <= 1'b1;
                  r_src_sel  <= bus.d_in[3:2] == CHIP_ID;
                  r_src_reg  <= bus.d_in[1:0];
               end
            end
            if (w_phase == PH_X3) begin
               r_io_pend  <= 1'b0;
               r_src_pend <= 1'b0;
               if (r_src_pend) r_sel <= r_src_sel;
               if (r_src_pend && r_src_sel) r_addr <= {r_src_reg, bus.d_in};
            end
         end
      end
   end
   assign bus.ram_addr    = r_addr;
   assign bus.ram_opa     = r_opa;
   assign bus.ram_cs      = r_cs;
   assign bus.ram_we      = r_we;
   assign bus.ram_din     = r_din;
   assign bus.ram_reset_n = r_init_done;
   assign bus.d_out       = r_dout;
   assign bus.d_oe        = r_oe;
   assign bus.phase       = w_phase;
   assign bus.sync_err    = w_sync_err;
endmodule

// File: tb/tb_ram4002_bus_seq.sv
// tb_ram4002_bus_seq: instruction-cycle level reference model driven with directed and random bus traffic
module tb_ram4002_bus_seq;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;
   logic       m_sel = 1'b0;
   logic       m_err = 1'b0;
   logic [5:0] m_addr = 6'd0;
   ram4002_bus_seq_if bus();
   ram4002_bus_seq #(.CHIP_ID(2'd0), .INIT_CYCLES(64)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic bit rd_op(input logic [3:0] op);
      return op == 4'h8 || op == 4'h9 || op >= 4'hB;
   endfunction
   function automatic bit wr_op(input logic [3:0] op);
      return op <= 4'h1 || (op >= 4'h4 && op <= 4'h7);
   endfunction
   function automatic logic [31:0] mk(input logic [3:0] m2, input logic [3:0] x2, input logic [3:0] x3);
      return {x3, x2, 4'h0, m2, 16'h0};
   endfunction
   // one instruction cycle, entered just after the clock that made phase A1;
   // stop: 7 normal sync in X3, 8 no sync at all, 0..4 sync in that phase
   task automatic do_cycle(input logic [31:0] dv, input logic [7:0] cmv, input logic [3:0] rdv, input int stop);
      logic [3:0] op;
      bit io, rd, wr;
      op = dv[16 +: 4];
      io = stop >= 7 && cmv[4] && m_sel;
      rd = io && rd_op(op);
      wr = io && wr_op(op);
      for (int p = 0; p < 8; p++) begin
         bus.sync     = (p == stop);
         bus.cm       = cmv[p];
         bus.d_in     = dv[p*4 +: 4];
         bus.ram_dout = rdv;
         @(negedge clk);
         chk("phase", 32'(bus.phase), p);
         chk("cs", 32'(bus.ram_cs), 32'((rd && p == 5) || (wr && p == 7)));
         chk("we", 32'(bus.ram_we), 32'(wr && p == 7));
         chk("oe", 32'(bus.d_oe), 32'(rd && p == 6));
         chk("sync_err", 32'(bus.sync_err), 32'(m_err));
         if (rd && p == 5) chk("rd_addr", 32'(bus.ram_addr), 32'(m_addr));
         if (wr && p == 7) begin
            chk("wr_addr", 32'(bus.ram_addr), 32'(m_addr));
            chk("din", 32'(bus.ram_din), 32'(dv[24 +: 4]));
         end
         if (rd && p == 6) chk("dout", 32'(bus.d_out), 32'(rdv));
         if (io && p >= 5) chk("opa", 32'(bus.ram_opa), 32'(op));
         @(posedge clk);
         #1;
         if (p == stop) break;
      end
      bus.sync = 1'b0;
      bus.cm   = 1'b0;
      if (stop != 7) m_err = 1'b1;
      if (stop >= 7 && cmv[6]) begin
         m_sel = dv[27:26] == 2'd0;
         if (m_sel) m_addr = {dv[25:24], dv[31:28]};
      end
   endtask
   initial begin
      reset = 1'b1;
      bus.sync = 1'b0; bus.cm = 1'b0; bus.d_in = 4'h0; bus.ram_dout = 4'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_phase", 32'(bus.phase), 0);
      chk("rst_rn", 32'(bus.ram_reset_n), 0);
      chk("rst_cs", 32'(bus.ram_cs), 0);
      chk("rst_oe", 32'(bus.d_oe), 0);
      chk("rst_err", 32'(bus.sync_err), 0);
      chk("rst_addr", 32'(bus.ram_addr), 0);
      chk("rst_dout", 32'(bus.d_out), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      // init window: bus traffic must be ignored, ram_reset_n low for 64 clocks
      for (int i = 0; i < 68; i++) begin
         bus.sync = (i < 60) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
         bus.cm   = 1'($urandom);
         bus.d_in = 4'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk("init_rn", 32'(bus.ram_reset_n), 32'(i >= 63));
         chk("init_cs", 32'(bus.ram_cs), 0);
         chk("init_oe", 32'(bus.d_oe), 0);
         chk("init_err", 32'(bus.sync_err), 0);
      end
      bus.cm = 1'b0;
      bus.sync = 1'b1;
      @(posedge clk);
      #1 bus.sync = 1'b0;
      do_cycle(mk(4'h0, 4'b0011, 4'h5), 8'h40, 4'h0, 7);
      chk("src_addr", 32'(bus.ram_addr), 32'h35);
      do_cycle(mk(4'h0, 4'hA, 4'h0), 8'h10, 4'h0, 7);
      chk("wrm_din", 32'(bus.ram_din), 32'hA);
      do_cycle(mk(4'h9, 4'h0, 4'h0), 8'h10, 4'hA, 7);
      do_cycle(mk(4'h0, 4'b0100, 4'h0), 8'h40, 4'h0, 7);
      do_cycle(mk(4'h0, 4'h3, 4'h0), 8'h10, 4'h0, 7);
      chk("nosel_addr", 32'(bus.ram_addr), 32'h35);
      do_cycle(mk(4'h0, 4'b0011, 4'h5), 8'h40, 4'h0, 7);
      do_cycle(mk(4'hA, 4'h0, 4'h0), 8'h10, 4'h7, 7);
      do_cycle(mk(4'h0, 4'b0010, 4'h9), 8'h50, 4'h0, 7);
      chk("late_src_addr", 32'(bus.ram_addr), 32'h29);
      do_cycle(mk(4'h0, 4'h0, 4'h0), 8'h00, 4'h0, 8);
      chk("wrap_err", 32'(bus.sync_err), 1);
      do_cycle(mk(4'hE, 4'h0, 4'h0), 8'h10, 4'h3, 3);
      do_cycle(mk(4'h0, 4'h0, 4'h0), 8'h00, 4'h0, 7);
      for (int n = 0; n < 300; n++) begin
         int stop;
         stop = ($urandom_range(0, 19) < 2) ? int'($urandom_range(0, 4)) : (($urandom_range(0, 9) == 0) ? 8 : 7);
         do_cycle($urandom, 8'($urandom), 4'($urandom), stop);
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rerst_rn", 32'(bus.ram_reset_n), 0);
      chk("rerst_err", 32'(bus.sync_err), 0);
      chk("rerst_addr", 32'(bus.ram_addr), 0);
      chk("rerst_cs", 32'(bus.ram_cs), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
